// File: rtl/minmax_pkg.sv
// Shared types and defaults for the min/max window tracker.
package minmax_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_e;

endpackage

// File: rtl/minmax_cmp_unit.sv
// Combinational magnitude compare of a against b.
// Signed two's-complement when MINMAX_SIGNED_EN is defined, unsigned otherwise.
module cmp_unit #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              lt,
    output logic              gt,
    output logic              eq
);

`ifdef MINMAX_SIGNED_EN
    assign lt = $signed(a) < $signed(b);
    assign gt = $signed(a) > $signed(b);
`else
    assign lt = a < b;
    assign gt = a > b;
`endif
    assign eq = (a == b);

endmodule

// File: rtl/minmax_tracker.sv
// Tracks min, max and saturating sample count over s_last-delimited windows.
// Build option MINMAX_SIGNED_EN selects signed compares (see cmp_unit).
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_min,
    output logic [DATA_W-1:0] m_max,
    output logic [CNT_W-1:0]  m_count
);

    // Handshakes: a transfer happens on the rising edge where valid && ready;
    // a source never withdraws valid on its own and ready never depends on valid.

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   min_q, min_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                m_valid_q, m_valid_d;
    logic                accept;

    logic min_lt, min_gt, min_eq;
    logic max_lt, max_gt, max_eq;
    logic unused_cmp;

    cmp_unit #(.DATA_W(DATA_W)) u_cmp_min (
        .a  (s_data),
        .b  (min_q),
        .lt (min_lt),
        .gt (min_gt),
        .eq (min_eq)
    );

    cmp_unit #(.DATA_W(DATA_W)) u_cmp_max (
        .a  (s_data),
        .b  (max_q),
        .lt (max_lt),
        .gt (max_gt),
        .eq (max_eq)
    );

    assign unused_cmp = &{1'b0, min_gt, min_eq, max_lt, max_eq};

    // Gated by rst_n so the source sees no readiness while held in reset.
    assign s_ready = rst_n && (state_q != OUTPUT);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    min_d = s_data;
                    max_d = s_data;
                    cnt_d = CNT_W'(1);
                    if (s_last) begin
                        state_d   = OUTPUT;
                        m_valid_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (min_lt) min_d = s_data;
                    if (max_gt) max_d = s_data;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                    if (s_last) begin
                        state_d   = OUTPUT;
                        m_valid_d = 1'b1;
                    end
                end
            end
            OUTPUT: begin
                if (m_ready) begin
                    state_d   = IDLE;
                    m_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            min_q     <= '0;
            max_q     <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            max_q     <= max_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_min   = min_q;
    assign m_max   = max_q;
    assign m_count = cnt_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker; expectations follow MINMAX_SIGNED_EN.
module tb_minmax_tracker;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_min;
    logic [DATA_W-1:0] m_max;
    logic [CNT_W-1:0]  m_count;

    int n_checks = 0;
    int n_errors = 0;

    minmax_tracker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_min   (m_min),
        .m_max   (m_max),
        .m_count (m_count)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver: present one sample at the falling edge, transfer on the next rising edge
    task automatic send(input logic [DATA_W-1:0] data, input logic last);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        chk("s_ready_when_sending", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // result check right after last acceptance, then handshake
    task automatic collect(input string tag, input logic [DATA_W-1:0] e_min,
                           input logic [DATA_W-1:0] e_max, input logic [CNT_W-1:0] e_cnt);
        chk({tag, "_m_valid_latency"}, 32'(m_valid), 32'd1);
        chk({tag, "_s_ready_low"}, 32'(s_ready), 32'd0);
        chk({tag, "_min"}, 32'(m_min), 32'(e_min));
        chk({tag, "_max"}, 32'(m_max), 32'(e_max));
        chk({tag, "_count"}, 32'(m_count), 32'(e_cnt));
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk({tag, "_m_valid_cleared"}, 32'(m_valid), 32'd0);
        chk({tag, "_s_ready_back"}, 32'(s_ready), 32'd1);
        chk({tag, "_min_held"}, 32'(m_min), 32'(e_min));
        chk({tag, "_max_held"}, 32'(m_max), 32'(e_max));
        chk({tag, "_count_held"}, 32'(m_count), 32'(e_cnt));
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;

        // reset state
        idle_cycles(2);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_min", 32'(m_min), 32'd0);
        chk("rst_max", 32'(m_max), 32'd0);
        chk("rst_count", 32'(m_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);

        // basic unsigned window, with an idle gap mid-window
        send(16'h0010, 1'b0);
        chk("w1_no_early_valid", 32'(m_valid), 32'd0);
        idle_cycles(2);
        send(16'h0005, 1'b0);
        send(16'h0020, 1'b1);
        collect("w1", 16'h0005, 16'h0020, 8'd3);

        // single-sample window
        send(16'hABCD, 1'b1);
        collect("single", 16'hABCD, 16'hABCD, 8'd1);

        // equal samples keep min/max
        send(16'h0005, 1'b0);
        send(16'h0005, 1'b0);
        send(16'h0005, 1'b1);
        collect("equal", 16'h0005, 16'h0005, 8'd3);

        // sign-sensitive window
        send(16'hFFFF, 1'b0);
        send(16'h0001, 1'b1);
`ifdef MINMAX_SIGNED_EN
        collect("signed", 16'hFFFF, 16'h0001, 8'd2);
`else
        collect("unsigned", 16'h0001, 16'hFFFF, 8'd2);
`endif

        // back-pressure: m_ready low 5 cycles with spurious s_valid
        send(16'h0300, 1'b0);
        send(16'h0200, 1'b0);
        send(16'h0400, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 16'h7777;
            s_last  = 1'b1;
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("bp_m_valid", 32'(m_valid), 32'd1);
            chk("bp_min", 32'(m_min), 32'h0200);
            chk("bp_max", 32'(m_max), 32'h0400);
            chk("bp_count", 32'(m_count), 32'd3);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        // state-neutral re-entry: collect checks m_valid still high and values
        collect("bp", 16'h0200, 16'h0400, 8'd3);
        send(16'h0100, 1'b0);
        send(16'h0080, 1'b1);
        collect("after_bp", 16'h0080, 16'h0100, 8'd2);

        // saturating count over 300 samples
        for (int i = 0; i < 299; i++) send(16'(i + 100), 1'b0);
        send(16'd399, 1'b1);
        collect("sat", 16'd100, 16'd399, 8'd255);

        // reset mid-window discards partial result
        send(16'h0050, 1'b0);
        send(16'h0060, 1'b0);
        chk("mid_pre_rst_max", 32'(m_max), 32'h0060);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
        chk("mid_rst_min", 32'(m_min), 32'd0);
        chk("mid_rst_max", 32'(m_max), 32'd0);
        chk("mid_rst_count", 32'(m_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);
        chk("mid_no_stale_valid", 32'(m_valid), 32'd0);
        send(16'h0009, 1'b0);
        send(16'h0003, 1'b1);
        collect("post_rst", 16'h0003, 16'h0009, 8'd2);

        // reset while a result is pending
        send(16'h0044, 1'b1);
        chk("pend_valid", 32'(m_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("pend_rst_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);
        chk("pend_no_valid", 32'(m_valid), 32'd0);
        chk("pend_s_ready", 32'(s_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
